// File: rtl/maria_bus_arbiter.sv
// CPU/MARIA bus arbiter: halts the 6502 and grants MARIA the bus once the CPU has
// finished its setup reads, and holds RDY low from a WSYNC strobe until hblank.
module maria_bus_arbiter #(
  parameter int unsigned HALT_SETUP = 2,
  parameter bit          WSYNC_EN   = 1'b1
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       pclk0,
  input  logic       cpu_rw,
  input  logic       deassert_ready,
  input  logic       hblank_start,
  input  logic       dma_req,
  input  logic       dma_done,
  output logic       rdy,
  output logic       halt,
  output logic       drive_AB,
  output logic [1:0] arb_state
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HALT_PEND = 2'd1,
    ST_DMA       = 2'd2,
    ST_RELEASE   = 2'd3
  } state_t;

  localparam logic [2:0] SETUP_CNT = 3'(HALT_SETUP);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       wsync_q, wsync_d;
  logic       rdy_q, rdy_d;
  logic       halt_q, halt_d;
  logic       drive_ab_q, drive_ab_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wsync_d = wsync_q;

    // hblank wins over a coincident strobe
    if (hblank_start) begin
      wsync_d = 1'b0;
    end else if (pclk0 && deassert_ready && WSYNC_EN) begin
      wsync_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (dma_req) begin
          state_d = ST_HALT_PEND;
          cnt_d   = 3'd0;
        end
      end
      ST_HALT_PEND: begin
        // Only read cycles count: the 6502 ignores RDY during writes.
        if (!dma_req) begin
          state_d = ST_IDLE;
        end else if (pclk0 && cpu_rw) begin
          if (cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;
          if (cnt_d == SETUP_CNT) state_d = ST_DMA;
        end
      end
      ST_DMA: begin
        if (dma_done) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (pclk0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from next state so they register alongside it.
    halt_d     = (state_d != ST_IDLE);
    drive_ab_d = (state_d == ST_DMA);
    rdy_d      = (state_d == ST_IDLE) && !wsync_d;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      wsync_q    <= 1'b0;
      rdy_q      <= 1'b1;
      halt_q     <= 1'b0;
      drive_ab_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wsync_q    <= wsync_d;
      rdy_q      <= rdy_d;
      halt_q     <= halt_d;
      drive_ab_q <= drive_ab_d;
    end
  end

  assign rdy       = rdy_q;
  assign halt      = halt_q;
  assign drive_AB  = drive_ab_q;
  assign arb_state = state_q;

endmodule

// File: tb/tb_maria_bus_arbiter.sv
// Self-checking bench for maria_bus_arbiter: vector table, hand sequences, random vs model.
module tb_maria_bus_arbiter;

  localparam int HALT_SETUP = 2;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       pclk0 = 1'b0;
  logic       cpu_rw = 1'b0;
  logic       deassert_ready = 1'b0;
  logic       hblank_start = 1'b0;
  logic       dma_req = 1'b0;
  logic       dma_done = 1'b0;
  logic       rdy, halt, drive_AB;
  logic [1:0] arb_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bus owner phase, reads seen since halt, wsync flag.
  int m_st = 0;
  int m_reads = 0;
  bit m_ws = 1'b0;

  maria_bus_arbiter #(.HALT_SETUP(HALT_SETUP), .WSYNC_EN(1'b1)) dut (
    .clk_sys(clk_sys), .reset(reset), .pclk0(pclk0), .cpu_rw(cpu_rw),
    .deassert_ready(deassert_ready), .hblank_start(hblank_start),
    .dma_req(dma_req), .dma_done(dma_done), .rdy(rdy), .halt(halt),
    .drive_AB(drive_AB), .arb_state(arb_state)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    bit rst, p, rw, dr, hb, req, done;
    int st;
    bit e_rdy, e_halt, e_ab;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, p, rw, dr, hb, req, done);
    if (rst) begin
      m_st = 0; m_reads = 0; m_ws = 1'b0;
    end else begin
      if (hb) m_ws = 1'b0;
      else if (p && dr) m_ws = 1'b1;
      if (m_st == 0) begin
        if (req) begin m_st = 1; m_reads = 0; end
      end else if (m_st == 1) begin
        if (!req) m_st = 0;
        else if (p && rw) begin
          m_reads++;
          if (m_reads >= HALT_SETUP) m_st = 2;
        end
      end else if (m_st == 2) begin
        if (done) m_st = 3;
      end else begin
        if (p) m_st = 0;
      end
    end
  endtask

  task automatic drive(input bit rst, p, rw, dr, hb, req, done);
    reset = rst; pclk0 = p; cpu_rw = rw; deassert_ready = dr;
    hblank_start = hb; dma_req = req; dma_done = done;
    @(posedge clk_sys);
    #1;
    model_step(rst, p, rw, dr, hb, req, done);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_all(input string nm, input int st, input bit r, h, ab);
    chk({nm, ".state"}, int'(arb_state), st);
    chk({nm, ".rdy"}, int'(rdy), int'(r));
    chk({nm, ".halt"}, int'(halt), int'(h));
    chk({nm, ".drive_AB"}, int'(drive_AB), int'(ab));
  endtask

  task automatic add(input bit rst, p, rw, dr, hb, req, done, input int st, input bit r, h, ab);
    vec_t v;
    v.rst = rst; v.p = p; v.rw = rw; v.dr = dr; v.hb = hb; v.req = req; v.done = done;
    v.st = st; v.e_rdy = r; v.e_halt = h; v.e_ab = ab;
    vt.push_back(v);
  endtask

  initial begin
    bit ab_seen;
    bit r_rst, r_p, r_rw, r_dr, r_hb, r_req, r_done;

    //   rst p rw dr hb req done | st rdy halt ab
    add(1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0);  // reset state
    add(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0,   1, 0, 1, 0);  // halt one clk after request
    add(0, 1, 1, 0, 0, 1, 0,   1, 0, 1, 0);  // read 1
    add(0, 0, 0, 0, 0, 1, 0,   1, 0, 1, 0);
    add(0, 1, 1, 0, 0, 1, 0,   2, 0, 1, 1);  // read 2 -> grant
    add(0, 0, 0, 0, 0, 1, 0,   2, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0,   2, 0, 1, 1);  // req drop alone keeps DMA
    add(0, 0, 0, 0, 0, 0, 1,   3, 0, 1, 0);  // done -> RELEASE
    add(0, 0, 0, 0, 0, 0, 0,   3, 0, 1, 0);
    add(0, 1, 1, 0, 0, 0, 0,   0, 1, 0, 0);  // turnaround pclk0 -> IDLE
    add(0, 0, 0, 0, 0, 1, 0,   1, 0, 1, 0);  // write stretch
    add(0, 1, 0, 0, 0, 1, 0,   1, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 0,   1, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 0,   1, 0, 1, 0);
    add(0, 1, 1, 0, 0, 1, 0,   1, 0, 1, 0);
    add(0, 1, 1, 0, 0, 1, 0,   2, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 1,   3, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0);  // stray dma_done ignored

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].p, vt[i].rw, vt[i].dr, vt[i].hb, vt[i].req, vt[i].done);
      chk_all($sformatf("vec%0d", i), vt[i].st, vt[i].e_rdy, vt[i].e_halt, vt[i].e_ab);
    end

    // WSYNC hold until hblank
    drive(0, 1, 0, 1, 0, 0, 0);
    chk("wsync.rdy_low", int'(rdy), 0);
    idle(99);
    chk("wsync.rdy_held", int'(rdy), 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("wsync.rdy_hblank", int'(rdy), 1);
    drive(0, 1, 0, 1, 1, 0, 0);
    chk("wsync.hblank_wins", int'(rdy), 1);

    // WSYNC overlapping a DMA
    drive(0, 1, 0, 1, 0, 1, 0);
    chk_all("ovl.strobe_req", 1, 0, 1, 0);
    drive(0, 1, 1, 0, 0, 1, 0);
    drive(0, 1, 1, 0, 0, 1, 0);
    chk_all("ovl.dma", 2, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 1, 0, 0, 0, 0);
    chk_all("ovl.after_release", 0, 0, 0, 0);
    idle(5);
    chk("ovl.rdy_held", int'(rdy), 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("ovl.rdy_hblank", int'(rdy), 1);

    // Abort after one read, then abort coinciding with completing read
    ab_seen = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 0);   ab_seen |= drive_AB;
    drive(0, 1, 1, 0, 0, 1, 0);   ab_seen |= drive_AB;
    drive(0, 0, 0, 0, 0, 0, 0);   ab_seen |= drive_AB;
    chk_all("abort.idle", 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0);   ab_seen |= drive_AB;
    drive(0, 1, 1, 0, 0, 1, 0);   ab_seen |= drive_AB;
    drive(0, 1, 1, 0, 0, 0, 0);   ab_seen |= drive_AB;
    chk_all("abort.priority", 0, 1, 0, 0);
    chk("abort.no_grant", int'(ab_seen), 0);

    // Reset mid-DMA overrides live inputs
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 1, 1, 0, 0, 1, 0);
    drive(0, 1, 1, 0, 0, 1, 0);
    chk("rst.in_dma", int'(drive_AB), 1);
    drive(1, 1, 1, 1, 0, 1, 0);
    chk_all("rst.mid_dma", 0, 1, 0, 0);

    // Random traffic against the model
    r_req = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      r_rst  = ($urandom_range(0, 499) == 0);
      r_p    = ($urandom_range(0, 3) == 0);
      r_rw   = $urandom_range(0, 1) != 0;
      r_dr   = ($urandom_range(0, 15) == 0);
      r_hb   = ($urandom_range(0, 39) == 0);
      r_done = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) r_req = ~r_req;
      drive(r_rst, r_p, r_rw, r_dr, r_hb, r_req, r_done);
      chk_all($sformatf("rnd%0d", c), m_st, (m_st == 0) && !m_ws, m_st != 0, m_st == 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
